input_sequence_rx: RTL and testbench
====================================

Name: input_sequence_rx

Overview:
- Receive side of the colour-sequence interface; complements the display path that drives uo_out[3:0].
- Takes the four raw player buttons (ui_in[3:0], one-hot), then synchronises, debounces and decodes them into 2-bit colour codes.
- Packs the accepted presses into a 32-bit sequence word in the same layout the memory and checker use.
- Signals completion when the round's length has been entered, or when the player times out.
- Sits between the button pins and check_state, as a hardened replacement for the capture logic in the WAIT phase.

Parameters:
- DEBOUNCE_CYCLES, 120000: cycles the button pattern must be stable before it is accepted (10 ms at 12 MHz).
- TIMEOUT_CYCLES, 36000000: cycles allowed with no accepted press before timeout (3 s at 12 MHz).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- en  in  1  capture enable; high for the whole WAIT phase
- btn_in  in  4  raw buttons, asynchronous; bit i = colour i
- seq_len  in  4  round counter; expected presses = seq_len+1 (range 1..16)
- seq_out  out  32  captured sequence; press k occupies bits [2k+1:2k]
- press_valid  out  1  one-cycle strobe when a press is accepted
- press_colour  out  2  colour of the most recent accepted press
- invalid  out  1  one-cycle strobe when a debounced multi-button pattern is seen
- complete  out  1  level; capture finished (normal or timeout)
- timeout  out  1  level; the capture finished because of timeout

Behaviour:
- Reset:
  - All outputs are 0.
  - FSM goes to IDLE; press count, debounce counter and timeout counter are 0.
  - Synchroniser flops are 0.
- Input path:
  - 2-FF synchroniser on btn_in produces sync_btn.
  - Debouncer: stable_btn updates to sync_btn after sync_btn has been unchanged for DEBOUNCE_CYCLES consecutive cycles. Any change reloads the counter.
- Decode of stable_btn:
  - 0001→00, 0010→01, 0100→10, 1000→11.
  - 0000 = released.
  - Any other pattern = multi-press.
- FSM states: IDLE, WAIT_PRESS, WAIT_RELEASE, DONE.
- IDLE:
  - Entered when en is low.
  - On en high: clear seq_out, press count and timeout counter, then go to WAIT_PRESS.
- WAIT_PRESS:
  - One-hot stable_btn:
    - write the colour to seq_out[2*cnt+1:2*cnt];
    - press_colour ← colour; pulse press_valid;
    - cnt++; clear the timeout counter;
    - go to WAIT_RELEASE.
  - Multi-press: pulse invalid once per entry into that pattern. Nothing is stored; stay in WAIT_PRESS.
  - Timeout counter increments each cycle in this state. When it reaches TIMEOUT_CYCLES-1: timeout←1, complete←1, go to DONE.
- WAIT_RELEASE:
  - Leave only when stable_btn == 0000.
  - If cnt == seq_len+1, go to DONE with complete←1. Otherwise go to WAIT_PRESS.
  - The release requirement stops one held button from counting twice.
  - No timeout is counted in this state.
- DONE:
  - complete, timeout and seq_out are held.
  - New presses are ignored.
  - Leave to IDLE when en goes low.
- en low in any state: go to IDLE on the next edge and clear complete and timeout. seq_out holds until the next IDLE→WAIT_PRESS transition.
- Latency: press_valid rises 2 (synchroniser) + DEBOUNCE_CYCLES + 1 cycles after a clean btn_in edge.
- Widths and limits:
  - Press count is 5 bits, so 16 presses can be represented.
  - seq_len=15 fills all 32 bits.
  - Bits above 2*(seq_len+1) stay 0.
- rst high mid-operation wins over everything and returns the block to the reset state on the next edge.

Decomposition:
- Shared package simon_pkg holds:
  - colour code constants COL_0..COL_3 (2'b00..2'b11);
  - the FSM state encoding (2 bits);
  - SEQ_W = 32 and MAX_LEN = 16.
- One sub-module, btn_debounce: parameter DEBOUNCE_CYCLES, WIDTH = 4. Contains the 2-FF synchroniser and the stability counter; output stable_btn.

Test Plan:
- With DEBOUNCE_CYCLES=4, seq_len=2, en=1: press 0010, 1000, 0001, each held 10 cycles with 10-cycle gaps → three press_valid pulses, seq_out=32'h0000_000D (01,11,00), complete=1, timeout=0.
- Bounce: toggle btn_in 0100/0000 every 2 cycles for 12 cycles, then hold 0100 → exactly one press_valid with press_colour=10.
- Hold 0001 for 200 cycles with seq_len=3 → a single press is recorded; cnt does not advance until release.
- Press 0011 and hold → one invalid pulse, no press_valid, seq_out unchanged. Then release and press 0100 → accepted as the first press.
- With TIMEOUT_CYCLES=50 and seq_len=3: one press, then idle for 60 cycles → complete=1, timeout=1, seq_out holds the first colour.
- Drop en in WAIT_RELEASE after 2 presses, then raise it again → IDLE, then seq_out cleared, cnt=0; rst pulsed mid-capture → all outputs 0 on the next edge.

Source files
------------

// File: rtl/simon_pkg.sv
// Shared definitions for the colour-sequence game: colour codes, capture FSM encoding
// and sequence-word geometry.
package simon_pkg;

    localparam int unsigned SEQ_W   = 32;
    localparam int unsigned MAX_LEN = 16;

    localparam logic [1:0] COL_0 = 2'b00;
    localparam logic [1:0] COL_1 = 2'b01;
    localparam logic [1:0] COL_2 = 2'b10;
    localparam logic [1:0] COL_3 = 2'b11;

    typedef enum logic [1:0] {
        StIdle        = 2'd0,
        StWaitPress   = 2'd1,
        StWaitRelease = 2'd2,
        StDone        = 2'd3
    } state_e;

    // Only meaningful for one-hot inputs; callers qualify with $onehot first.
    function automatic logic [1:0] btn_colour(input logic [3:0] btn);
        logic [1:0] col;
        case (btn)
            4'b0001: col = COL_0;
            4'b0010: col = COL_1;
            4'b0100: col = COL_2;
            4'b1000: col = COL_3;
            default: col = COL_0;
        endcase
        return col;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a stability counter; stable_btn only follows the
// synchronised pattern once it has held still for DEBOUNCE_CYCLES cycles.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 120000,
    parameter int unsigned WIDTH           = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] btn_in,
    output logic [WIDTH-1:0] stable_btn
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES);

    logic [WIDTH-1:0] sync1_q, sync2_q, last_q;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    // cnt_d is the run length of identical synchronised samples, saturating at CntMax.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync2_q != last_q) begin
            cnt_d = CntW'(1);
        end else if (cnt_q != CntMax) begin
            cnt_d = cnt_q + CntW'(1);
        end
        if (cnt_d == CntMax) begin
            stable_d = sync2_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            last_q   <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= btn_in;
            sync2_q  <= sync1_q;
            last_q   <= sync2_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_btn = stable_q;

endmodule

// File: rtl/input_sequence_rx.sv
// Button capture for the WAIT phase: debounces the four colour buttons, packs accepted
// presses two bits each into a sequence word and flags completion or timeout.
module input_sequence_rx import simon_pkg::*; #(
    parameter int unsigned DEBOUNCE_CYCLES = 120000,
    parameter int unsigned TIMEOUT_CYCLES  = 36000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [3:0]       btn_in,
    input  logic [3:0]       seq_len,
    output logic [SEQ_W-1:0] seq_out,
    output logic             press_valid,
    output logic [1:0]       press_colour,
    output logic             invalid,
    output logic             complete,
    output logic             timeout
);

    localparam int unsigned CntW = $clog2(MAX_LEN + 1);
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

    state_e           state_q, state_d;
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [TmoW-1:0]  tmo_q, tmo_d;
    logic [1:0]       colour_q, colour_d;
    logic [3:0]       flagged_q, flagged_d;
    logic             press_valid_q, press_valid_d;
    logic             invalid_q, invalid_d;
    logic             complete_q, complete_d;
    logic             timeout_q, timeout_d;

    logic [3:0]      stable_btn;
    logic            one_hot, released, multi;
    logic [CntW-1:0] target;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .WIDTH          (4)
    ) u_debounce (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_in),
        .stable_btn(stable_btn)
    );

    assign one_hot  = $onehot(stable_btn);
    assign released = (stable_btn == 4'b0000);
    assign multi    = !one_hot && !released;
    assign target   = CntW'(seq_len) + CntW'(1);

    always_comb begin
        state_d       = state_q;
        seq_d         = seq_q;
        cnt_d         = cnt_q;
        tmo_d         = tmo_q;
        colour_d      = colour_q;
        flagged_d     = '0;
        press_valid_d = 1'b0;
        invalid_d     = 1'b0;
        complete_d    = complete_q;
        timeout_d     = timeout_q;

        if (!en) begin
            state_d    = StIdle;
            complete_d = 1'b0;
            timeout_d  = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    seq_d   = '0;
                    cnt_d   = '0;
                    tmo_d   = '0;
                    state_d = StWaitPress;
                end
                StWaitPress: begin
                    if (one_hot) begin
                        seq_d[{cnt_q[3:0], 1'b0} +: 2] = btn_colour(stable_btn);
                        colour_d      = btn_colour(stable_btn);
                        press_valid_d = 1'b1;
                        cnt_d         = cnt_q + CntW'(1);
                        tmo_d         = '0;
                        state_d       = StWaitRelease;
                    end else begin
                        // Remember the flagged pattern so a held chord pulses only once.
                        if (multi) begin
                            flagged_d = stable_btn;
                            invalid_d = (stable_btn != flagged_q);
                        end
                        if (tmo_q == TmoLast) begin
                            timeout_d  = 1'b1;
                            complete_d = 1'b1;
                            state_d    = StDone;
                        end else begin
                            tmo_d = tmo_q + TmoW'(1);
                        end
                    end
                end
                StWaitRelease: begin
                    if (released) begin
                        if (cnt_q == target) begin
                            complete_d = 1'b1;
                            state_d    = StDone;
                        end else begin
                            state_d = StWaitPress;
                        end
                    end
                end
                StDone:  state_d = StDone;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            seq_q         <= '0;
            cnt_q         <= '0;
            tmo_q         <= '0;
            colour_q      <= '0;
            flagged_q     <= '0;
            press_valid_q <= 1'b0;
            invalid_q     <= 1'b0;
            complete_q    <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            seq_q         <= seq_d;
            cnt_q         <= cnt_d;
            tmo_q         <= tmo_d;
            colour_q      <= colour_d;
            flagged_q     <= flagged_d;
            press_valid_q <= press_valid_d;
            invalid_q     <= invalid_d;
            complete_q    <= complete_d;
            timeout_q     <= timeout_d;
        end
    end

    assign seq_out      = seq_q;
    assign press_valid  = press_valid_q;
    assign press_colour = colour_q;
    assign invalid      = invalid_q;
    assign complete     = complete_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_input_sequence_rx.sv
// Bench for input_sequence_rx: directed scenarios plus random button traffic, every cycle
// compared against a sample-window reference model of the capture rules.
module tb_input_sequence_rx;

    localparam int unsigned DEB = 4;
    localparam int unsigned TMO = 50;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  btn_in;
    logic [3:0]  seq_len;
    logic [31:0] seq_out;
    logic        press_valid;
    logic [1:0]  press_colour;
    logic        invalid;
    logic        complete;
    logic        timeout;

    input_sequence_rx #(
        .DEBOUNCE_CYCLES(DEB),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .btn_in      (btn_in),
        .seq_len     (seq_len),
        .seq_out     (seq_out),
        .press_valid (press_valid),
        .press_colour(press_colour),
        .invalid     (invalid),
        .complete    (complete),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pv_seen = 0;
    int inv_seen = 0;

    // Reference model state: raw button samples, newest first, plus capture progress.
    logic [3:0]  hist[$];
    logic [3:0]  m_stable;
    bit          m_active, m_need_release, m_finished;
    int          m_count, m_waited;
    logic [31:0] m_seq;
    logic [1:0]  m_colour;
    logic [3:0]  m_flagged;
    bit          m_pv, m_inv, m_complete, m_timeout;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int ones(input logic [3:0] b);
        return int'(b[0]) + int'(b[1]) + int'(b[2]) + int'(b[3]);
    endfunction

    task automatic model_step();
        logic [3:0] s;
        bit         waiting;
        bit         steady;
        s       = m_stable;
        waiting = 1'b0;
        m_pv    = 1'b0;
        m_inv   = 1'b0;
        if (rst) begin
            hist.delete();
            for (int k = 0; k < DEB + 2; k++) hist.push_back(4'b0000);
            m_stable = '0; m_active = 0; m_need_release = 0; m_finished = 0;
            m_count = 0; m_waited = 0; m_seq = '0; m_colour = '0; m_flagged = '0;
            m_complete = 0; m_timeout = 0;
            return;
        end
        if (!en) begin
            m_active = 0; m_complete = 0; m_timeout = 0;
        end else if (!m_active) begin
            m_active = 1; m_need_release = 0; m_finished = 0;
            m_count = 0; m_waited = 0; m_seq = '0;
        end else if (m_finished) begin
            m_finished = 1;
        end else if (m_need_release) begin
            if (s == 4'b0000) begin
                m_need_release = 0;
                if (m_count == int'(seq_len) + 1) begin
                    m_finished = 1; m_complete = 1;
                end
            end
        end else begin
            waiting = 1'b1;
            if (ones(s) == 1) begin
                for (int i = 0; i < 4; i++) if (s[i]) m_colour = 2'(i);
                m_seq[2*m_count +: 2] = m_colour;
                m_pv = 1; m_count++; m_waited = 0; m_need_release = 1;
            end else begin
                if (s != 4'b0000 && s != m_flagged) m_inv = 1;
                m_waited++;
                if (m_waited >= TMO) begin
                    m_finished = 1; m_timeout = 1; m_complete = 1;
                end
            end
        end
        m_flagged = (waiting && ones(s) > 1) ? s : 4'b0000;
        // A pattern becomes stable once DEB synchronised samples agree.
        hist.push_front(btn_in);
        while (hist.size() > DEB + 2) void'(hist.pop_back());
        steady = 1'b1;
        for (int k = 3; k <= DEB + 1; k++) if (hist[k] != hist[2]) steady = 1'b0;
        if (steady) m_stable = hist[2];
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        if (press_valid) pv_seen++;
        if (invalid) inv_seen++;
        check_eq("outs", {seq_out, press_valid, press_colour, invalid, complete, timeout},
                 {m_seq, m_pv, m_colour, m_inv, m_complete, m_timeout});
    endtask

    task automatic hold(input logic [3:0] b, input int n);
        btn_in = b;
        repeat (n) tick();
    endtask

    task automatic new_round(input logic [3:0] len);
        btn_in  = 4'b0000;
        en      = 1'b0;
        repeat (8) tick();
        seq_len = len;
        en      = 1'b1;
        tick();
        pv_seen  = 0;
        inv_seen = 0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; btn_in = 4'b0000; seq_len = 4'd0;
        repeat (3) tick();
        check_eq("rst_seq", seq_out, 0);
        check_eq("rst_flags", {press_valid, press_colour, invalid, complete, timeout}, 0);
        rst = 1'b0;

        // Three-press round.
        new_round(4'd2);
        hold(4'b0010, 10); hold(4'b0000, 10);
        hold(4'b1000, 10); hold(4'b0000, 10);
        hold(4'b0001, 10); hold(4'b0000, 10);
        check_eq("basic_seq", seq_out, 32'h0000_000D);
        check_eq("basic_pv", pv_seen, 3);
        check_eq("basic_done", {complete, timeout}, 2'b10);

        // Bouncing contact followed by a clean hold.
        new_round(4'd3);
        for (int k = 0; k < 3; k++) begin
            hold(4'b0100, 2); hold(4'b0000, 2);
        end
        hold(4'b0100, 20);
        check_eq("bounce_pv", pv_seen, 1);
        check_eq("bounce_col", press_colour, 2'b10);
        hold(4'b0000, 10);

        // Long hold counts once.
        new_round(4'd3);
        hold(4'b0001, 200);
        check_eq("long_pv", pv_seen, 1);
        hold(4'b0000, 10); hold(4'b0010, 10);
        check_eq("long_seq", seq_out, 32'h0000_0004);
        check_eq("long_pv2", pv_seen, 2);

        // Chord is rejected, then a real press lands in slot 0.
        new_round(4'd3);
        hold(4'b0011, 20);
        check_eq("chord_inv", inv_seen, 1);
        check_eq("chord_pv", pv_seen, 0);
        check_eq("chord_seq", seq_out, 0);
        hold(4'b0000, 10); hold(4'b0100, 10);
        check_eq("chord_then", seq_out, 32'h0000_0002);

        // Timeout after one press.
        new_round(4'd3);
        hold(4'b1000, 10); hold(4'b0000, 60);
        check_eq("tmo_flags", {complete, timeout}, 2'b11);
        check_eq("tmo_seq", seq_out, 32'h0000_0003);

        // Single-press round and full sixteen-press round.
        new_round(4'd0);
        hold(4'b0100, 10); hold(4'b0000, 10);
        check_eq("len1_done", {complete, timeout, seq_out}, {2'b10, 32'h0000_0002});
        new_round(4'd15);
        for (int k = 0; k < 16; k++) begin
            hold(4'(1 << (k % 4)), 10); hold(4'b0000, 10);
        end
        check_eq("len16_seq", seq_out, 32'hE4E4_E4E4);
        check_eq("len16_done", {complete, timeout}, 2'b10);

        // Drop en while a button is still held after two presses.
        new_round(4'd3);
        hold(4'b0001, 10); hold(4'b0000, 10); hold(4'b0010, 10);
        en = 1'b0;
        tick(); tick();
        check_eq("drop_hold", {complete, seq_out}, {1'b0, 32'h0000_0004});
        en = 1'b1;
        tick();
        check_eq("drop_clear", seq_out, 0);
        tick();
        check_eq("drop_repress", {press_valid, seq_out}, {1'b1, 32'h0000_0001});
        hold(4'b0000, 10);

        // Reset mid-capture.
        new_round(4'd3);
        hold(4'b0100, 10);
        rst = 1'b1;
        tick();
        check_eq("midrst", {seq_out, press_valid, press_colour, invalid, complete, timeout}, 0);
        rst = 1'b0;
        hold(4'b0000, 10);

        // Random traffic against the model.
        en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            int r;
            int p;
            logic [3:0] b;
            r = $urandom_range(0, 99);
            if (r < 3) begin
                rst = 1'b1; tick(); rst = 1'b0;
            end else if (r < 10) begin
                en = 1'b0;
                seq_len = 4'($urandom_range(0, 15));
                hold(4'($urandom_range(0, 15)), $urandom_range(1, 4));
                en = 1'b1;
            end
            p = $urandom_range(0, 9);
            if (p < 6)      b = 4'(1 << $urandom_range(0, 3));
            else if (p < 8) b = 4'b0000;
            else            b = 4'($urandom_range(0, 15));
            hold(b, $urandom_range(1, 12));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
